// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result buffers drained onto a multi-lane common data
// bus by a round-robin arbiter, with a registered physical-register wakeup mask.
module cdb_arbiter #(
    parameter int unsigned SRC_COUNT     = 6,
    parameter int unsigned LANES         = 2,
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter int unsigned PHY_REG_COUNT = 64,
    parameter int unsigned ROB_ID_WIDTH  = 5,
    localparam int unsigned PW           = $clog2(PHY_REG_COUNT)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic [SRC_COUNT-1:0]                      src_valid,
    output logic [SRC_COUNT-1:0]                      src_ready,
    input  logic [SRC_COUNT-1:0][PW-1:0]              src_prd,
    input  logic [SRC_COUNT-1:0][ROB_ID_WIDTH-1:0]    src_rob_id,
    input  logic [SRC_COUNT-1:0][31:0]                src_data,
    output logic [LANES-1:0]                          cdb_lane_valid,
    output logic [LANES-1:0][PW-1:0]                  cdb_lane_prd,
    output logic [LANES-1:0][ROB_ID_WIDTH-1:0]        cdb_lane_rob_id,
    output logic [LANES-1:0][31:0]                    cdb_lane_data,
    output logic [PHY_REG_COUNT-1:0]                  cdb_valid
);

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned SW  = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;
    localparam int unsigned SW1 = SW + 1;

    logic [PW-1:0]                mem_prd  [SRC_COUNT][FIFO_DEPTH];
    logic [ROB_ID_WIDTH-1:0]      mem_rob  [SRC_COUNT][FIFO_DEPTH];
    logic [DW-1:0]                mem_data [SRC_COUNT][FIFO_DEPTH];

    logic [SRC_COUNT-1:0][AW-1:0] head_q;
    logic [SRC_COUNT-1:0][AW-1:0] tail_q;
    logic [SRC_COUNT-1:0][CW-1:0] count_q;
    logic [SW-1:0]                rr_q;
    logic [SW-1:0]                rr_d;

    logic [SRC_COUNT-1:0]         enq;
    logic [SRC_COUNT-1:0]         deq;
    logic [SRC_COUNT-1:0]         nonempty;
    logic [SRC_COUNT-1:0]         taken;
    logic [SRC_COUNT-1:0][SW-1:0] scan_idx;
    logic [LANES-1:0]             hit;
    logic [LANES-1:0][SW-1:0]     lane_src;

    logic [LANES-1:0]                   lane_valid_d;
    logic [LANES-1:0][PW-1:0]           lane_prd_d;
    logic [LANES-1:0][ROB_ID_WIDTH-1:0] lane_rob_d;
    logic [LANES-1:0][DW-1:0]           lane_data_d;
    logic [PHY_REG_COUNT-1:0]           cdb_valid_d;

    // Buffer status from registered occupancy; accepted pushes are dropped on flush.
    always_comb begin
        src_ready = '0;
        nonempty  = '0;
        enq       = '0;
        for (int s = 0; s < SRC_COUNT; s++) begin
            src_ready[s] = (count_q[s] != CW'(FIFO_DEPTH));
            nonempty[s]  = (count_q[s] != '0);
            enq[s]       = src_valid[s] && src_ready[s] && !flush;
        end
    end

    // Source index visited at each scan position, starting from the round-robin pointer.
    always_comb begin
        logic [SW:0] sum;
        scan_idx = '0;
        sum      = '0;
        for (int k = 0; k < SRC_COUNT; k++) begin
            sum = {1'b0, rr_q} + SW1'(k);
            if (sum >= SW1'(SRC_COUNT)) begin
                sum = sum - SW1'(SRC_COUNT);
            end
            scan_idx[k] = sum[SW-1:0];
        end
    end

    // Each lane takes the next not-yet-granted non-empty source in scan order.
    always_comb begin
        taken    = '0;
        hit      = '0;
        lane_src = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < SRC_COUNT; k++) begin
                if (!hit[l] && nonempty[scan_idx[k]] && !taken[scan_idx[k]]) begin
                    hit[l]              = 1'b1;
                    lane_src[l]         = scan_idx[k];
                    taken[scan_idx[k]]  = 1'b1;
                end
            end
        end
        deq = flush ? '0 : taken;
    end

    // Pointer moves past the last source granted in scan order; held on idle or flush.
    always_comb begin
        rr_d = rr_q;
        for (int l = 0; l < LANES; l++) begin
            if (hit[l] && !flush) begin
                rr_d = (lane_src[l] == SW'(SRC_COUNT - 1)) ? '0 : lane_src[l] + SW'(1);
            end
        end
    end

    // Next lane payloads read from the granted heads, plus the matching wakeup mask.
    always_comb begin
        lane_valid_d = '0;
        lane_prd_d   = '0;
        lane_rob_d   = '0;
        lane_data_d  = '0;
        cdb_valid_d  = '0;
        for (int l = 0; l < LANES; l++) begin
            if (hit[l] && !flush) begin
                lane_valid_d[l] = 1'b1;
                lane_prd_d[l]   = mem_prd[lane_src[l]][head_q[lane_src[l]]];
                lane_rob_d[l]   = mem_rob[lane_src[l]][head_q[lane_src[l]]];
                lane_data_d[l]  = mem_data[lane_src[l]][head_q[lane_src[l]]];
                if (lane_prd_d[l] != '0) begin
                    cdb_valid_d[lane_prd_d[l]] = 1'b1;
                end
            end
        end
    end

    // FIFO storage writes; contents are only observed while occupancy covers them.
    always_ff @(posedge clk) begin
        for (int s = 0; s < SRC_COUNT; s++) begin
            if (enq[s]) begin
                mem_prd[s][tail_q[s]]  <= src_prd[s];
                mem_rob[s][tail_q[s]]  <= src_rob_id[s];
                mem_data[s][tail_q[s]] <= src_data[s];
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int s = 0; s < SRC_COUNT; s++) begin
                if (enq[s]) begin
                    tail_q[s] <= tail_q[s] + AW'(1);
                end
                if (deq[s]) begin
                    head_q[s] <= head_q[s] + AW'(1);
                end
                count_q[s] <= count_q[s] + CW'(enq[s]) - CW'(deq[s]);
            end
        end
    end

    // Registered CDB lanes, wakeup mask and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q            <= '0;
            cdb_lane_valid  <= '0;
            cdb_lane_prd    <= '0;
            cdb_lane_rob_id <= '0;
            cdb_lane_data   <= '0;
            cdb_valid       <= '0;
        end else begin
            rr_q            <= rr_d;
            cdb_lane_valid  <= lane_valid_d;
            cdb_lane_prd    <= lane_prd_d;
            cdb_lane_rob_id <= lane_rob_d;
            cdb_lane_data   <= lane_data_d;
            cdb_valid       <= cdb_valid_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus a per-source ordering scoreboard for cdb_arbiter.
module tb_cdb_arbiter;

    localparam int unsigned NS = 6;
    localparam int unsigned NL = 2;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic [NS-1:0]        src_valid;
    logic [NS-1:0]        src_ready;
    logic [NS-1:0][5:0]   src_prd;
    logic [NS-1:0][4:0]   src_rob_id;
    logic [NS-1:0][31:0]  src_data;
    logic [NL-1:0]        cdb_lane_valid;
    logic [NL-1:0][5:0]   cdb_lane_prd;
    logic [NL-1:0][4:0]   cdb_lane_rob_id;
    logic [NL-1:0][31:0]  cdb_lane_data;
    logic [63:0]          cdb_valid;

    cdb_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .src_prd         (src_prd),
        .src_rob_id      (src_rob_id),
        .src_data        (src_data),
        .cdb_lane_valid  (cdb_lane_valid),
        .cdb_lane_prd    (cdb_lane_prd),
        .cdb_lane_rob_id (cdb_lane_rob_id),
        .cdb_lane_data   (cdb_lane_data),
        .cdb_valid       (cdb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [5:0]  prd;
        logic [4:0]  rob;
        logic [31:0] data;
    } ent_t;

    ent_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    int   seq      = 4096;

    logic [NL-1:0]       snap_valid;
    logic [NL-1:0][5:0]  snap_prd;
    logic [NL-1:0][4:0]  snap_rob;
    logic [NL-1:0][31:0] snap_data;
    logic [63:0]         snap_cdb;
    logic [NS-1:0]       snap_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every valid lane must match the oldest outstanding result of its source.
    task automatic score_lanes();
        logic [63:0] mask;
        mask = '0;
        for (int l = 0; l < NL; l++) begin
            if (cdb_lane_valid[l] === 1'b1) begin
                int idx;
                int older;
                idx   = -1;
                older = 0;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (idx < 0 && exp_q[i].prd === cdb_lane_prd[l] &&
                        exp_q[i].rob === cdb_lane_rob_id[l] && exp_q[i].data === cdb_lane_data[l]) begin
                        idx = i;
                    end
                end
                check($sformatf("lane%0d_known data=0x%0h", l, cdb_lane_data[l]), 64'(idx >= 0), 64'd1);
                if (idx >= 0) begin
                    for (int i = 0; i < idx; i++) begin
                        if (exp_q[i].src == exp_q[idx].src) older++;
                    end
                    check($sformatf("lane%0d_order src%0d", l, exp_q[idx].src), 64'(older), 64'd0);
                    if (exp_q[idx].prd != 6'd0) mask[exp_q[idx].prd] = 1'b1;
                    exp_q.delete(idx);
                end
            end else begin
                check($sformatf("lane%0d_idle_payload", l),
                      64'({cdb_lane_prd[l], cdb_lane_rob_id[l], cdb_lane_data[l]}), 64'd0);
            end
        end
        check("cdb_valid_mask", cdb_valid, mask);
    endtask

    // Sample outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        snap_valid = cdb_lane_valid;
        snap_prd   = cdb_lane_prd;
        snap_rob   = cdb_lane_rob_id;
        snap_data  = cdb_lane_data;
        snap_cdb   = cdb_valid;
        snap_ready = src_ready;
        if (mon_en && rst === 1'b1) score_lanes();
    end

    // Record accepted handshakes, advance one clock, apply flush to the model.
    task automatic cycle();
        for (int s = 0; s < NS; s++) begin
            if (src_valid[s] && src_ready[s] && !flush) begin
                ent_t e;
                e.src  = s;
                e.prd  = src_prd[s];
                e.rob  = src_rob_id[s];
                e.data = src_data[s];
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        if (flush) exp_q.delete();
        #1;
    endtask

    task automatic set_src(input int s, input logic [5:0] p, input logic [4:0] r, input logic [31:0] d);
        src_valid[3'(s)]  = 1'b1;
        src_prd[3'(s)]    = p;
        src_rob_id[3'(s)] = r;
        src_data[3'(s)]   = d;
    endtask

    task automatic exp_lane(input string tag, input int l, input logic v,
                            input logic [5:0] p, input logic [4:0] r, input logic [31:0] d);
        check({tag, "_valid"}, 64'(snap_valid[1'(l)]), 64'(v));
        check({tag, "_payload"}, 64'({snap_prd[1'(l)], snap_rob[1'(l)], snap_data[1'(l)]}), 64'({p, r, d}));
    endtask

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        src_valid  = '0;
        src_prd    = '0;
        src_rob_id = '0;
        src_data   = '0;

        // Reset state
        #12;
        check("reset_lane_valid", 64'(cdb_lane_valid), 64'd0);
        check("reset_payload", 64'({cdb_lane_prd, cdb_lane_rob_id}) | 64'(cdb_lane_data), 64'd0);
        check("reset_cdb_valid", cdb_valid, 64'd0);
        check("reset_src_ready", 64'(src_ready), 64'h3f);
        @(posedge clk); #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        repeat (2) cycle();

        // Single result with two-cycle latency
        set_src(3, 6'd7, 5'd4, 32'hDEAD);
        check("single_ready", 64'(src_ready[3]), 64'd1);
        cycle();
        src_valid = '0;
        cycle();
        check("single_c1_lane0_valid", 64'(snap_valid[0]), 64'd0);
        cycle();
        exp_lane("single_c2_lane0", 0, 1'b1, 6'd7, 5'd4, 32'hDEAD);
        exp_lane("single_c2_lane1", 1, 1'b0, 6'd0, 5'd0, 32'h0);
        check("single_c2_cdb", snap_cdb, 64'd1 << 7);
        repeat (2) cycle();

        // prd=0 still broadcasts but wakes nothing
        set_src(5, 6'd0, 5'd9, 32'h55);
        cycle();
        src_valid = '0;
        repeat (2) cycle();
        exp_lane("prd0_lane0", 0, 1'b1, 6'd0, 5'd9, 32'h55);
        check("prd0_cdb", snap_cdb, 64'd0);
        repeat (2) cycle();

        // Contention among sources 0,1,2 from pointer 0
        set_src(0, 6'd1, 5'd10, 32'h100);
        set_src(1, 6'd2, 5'd11, 32'h101);
        set_src(2, 6'd3, 5'd12, 32'h102);
        cycle();
        src_valid = '0;
        repeat (2) cycle();
        exp_lane("cont_c2_lane0", 0, 1'b1, 6'd1, 5'd10, 32'h100);
        exp_lane("cont_c2_lane1", 1, 1'b1, 6'd2, 5'd11, 32'h101);
        check("cont_c2_cdb", snap_cdb, (64'd1 << 1) | (64'd1 << 2));
        cycle();
        exp_lane("cont_c3_lane0", 0, 1'b1, 6'd3, 5'd12, 32'h102);
        check("cont_c3_lane1_valid", 64'(snap_valid[1]), 64'd0);
        cycle();

        // Pointer now at 3: source 4 outranks source 1
        set_src(1, 6'd20, 5'd1, 32'h201);
        set_src(4, 6'd21, 5'd2, 32'h204);
        cycle();
        src_valid = '0;
        repeat (2) cycle();
        exp_lane("rr3_lane0", 0, 1'b1, 6'd21, 5'd2, 32'h204);
        exp_lane("rr3_lane1", 1, 1'b1, 6'd20, 5'd1, 32'h201);
        repeat (2) cycle();

        // Flush with three sources buffered; the flush-cycle push is dropped
        for (int a = 0; a < 2; a++) begin
            for (int s = 0; s < 3; s++) set_src(s, 6'(30 + s), 5'(a), 32'h3000 + 32'(a * 16 + s));
            cycle();
        end
        src_valid = '0;
        set_src(3, 6'd40, 5'd3, 32'h3333);
        flush = 1'b1;
        cycle();
        flush     = 1'b0;
        src_valid = '0;
        cycle();
        check("flush_lane_valid", 64'(snap_valid), 64'd0);
        check("flush_src_ready", 64'(snap_ready), 64'h3f);
        check("flush_cdb", snap_cdb, 64'd0);
        repeat (6) cycle();
        check("flush_never_emitted", 64'(snap_valid), 64'd0);

        // Asynchronous reset between edges while lanes are busy
        for (int a = 0; a < 2; a++) begin
            for (int s = 0; s < 4; s++) set_src(s, 6'(50 + s), 5'(a), 32'h5000 + 32'(a * 16 + s));
            cycle();
        end
        src_valid = '0;
        check("prereset_lane0_valid", 64'(cdb_lane_valid[0]), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("areset_lane_valid", 64'(cdb_lane_valid), 64'd0);
        check("areset_payload", 64'({cdb_lane_prd, cdb_lane_rob_id}) | 64'(cdb_lane_data), 64'd0);
        check("areset_cdb", cdb_valid, 64'd0);
        check("areset_src_ready", 64'(src_ready), 64'h3f);
        mon_en = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        set_src(0, 6'd11, 5'd1, 32'h0BAD0000);
        set_src(5, 6'd12, 5'd2, 32'h0BAD0005);
        cycle();
        src_valid = '0;
        repeat (2) cycle();
        exp_lane("postrst_lane0", 0, 1'b1, 6'd11, 5'd1, 32'h0BAD0000);
        exp_lane("postrst_lane1", 1, 1'b1, 6'd12, 5'd2, 32'h0BAD0005);
        check("postrst_cdb", snap_cdb, (64'd1 << 11) | (64'd1 << 12));
        repeat (4) cycle();

        // Backpressure: sources 0-4 stream every cycle
        for (int c = 0; c < 24; c++) begin
            for (int s = 0; s < 5; s++) begin
                set_src(s, 6'(s * 11 + seq), 5'(seq), {8'(s), 24'(seq)});
                seq++;
            end
            cycle();
            if (c == 2) begin
                check("bp_ready4_low", 64'(snap_ready[4]), 64'd0);
                check("bp_ready0_high", 64'(snap_ready[0]), 64'd1);
            end
        end
        src_valid = '0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter SRC_COUNT, default 6, number of functional-unit result sources (ALU, ALU1, ALU2, MUL, DIV, BRANCH in index order 0-5).
REQ-002 SHALL have parameter LANES, default 2, number of CDB broadcast lanes per cycle.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2 (power of two, >=2), result buffer entries per source.
REQ-004 SHALL have parameter PHY_REG_COUNT, default 64, physical register count; PW = $clog2(PHY_REG_COUNT).
REQ-005 SHALL have parameter ROB_ID_WIDTH, default 5, ROB tag width.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 flush  in  1  branch-mispredict squash, sampled synchronously.
REQ-010 src_valid  in  SRC_COUNT  per-source result valid.
REQ-011 src_ready  out  SRC_COUNT  per-source buffer not full.
REQ-012 src_prd  in  SRC_COUNT x PW  destination physical register.
REQ-013 src_rob_id  in  SRC_COUNT x ROB_ID_WIDTH  ROB tag.
REQ-014 src_data  in  SRC_COUNT x 32  result value.
REQ-015 cdb_lane_valid  out  LANES  lane broadcasting this cycle.
REQ-016 cdb_lane_prd / cdb_lane_rob_id / cdb_lane_data  out  LANES x PW / ROB_ID_WIDTH / 32  lane payload.
REQ-017 cdb_valid  out  PHY_REG_COUNT  wakeup mask consumed by the reservation station.

Function
REQ-018 SHALL keep one FIFO of FIFO_DEPTH entries per source, each entry {prd, rob_id, data}.
REQ-019 SHALL enqueue source s at a rising edge iff src_valid[s] && src_ready[s] && !flush.
REQ-020 SHALL drive src_ready[s] = !full[s] from registered occupancy only, with no same-cycle dequeue credit.
REQ-021 SHALL grant per cycle up to LANES non-empty FIFOs, scanning indices rr_ptr, rr_ptr+1, ... mod SRC_COUNT; the first hit goes to lane 0, the second to lane 1, and so on. At most one grant per source per cycle.
REQ-022 SHALL dequeue each granted FIFO head at the same edge that registers its payload onto the granted lane.
REQ-023 SHALL register all cdb_lane_* outputs. Minimum latency: handshake in cycle t -> visible on the CDB in cycle t+2.
REQ-024 SHALL drive cdb_lane_valid[l]=0 and zero payload on any lane with no grant.
REQ-025 SHALL update rr_ptr to (highest-scan-order granted index + 1) mod SRC_COUNT after a cycle with grants, and hold it otherwise.
REQ-026 SHALL compute cdb_valid[p]=1 iff some lane has cdb_lane_valid=1 and cdb_lane_prd=p, for p!=0; cdb_valid[0] is always 0.
REQ-027 SHALL still broadcast a valid lane when prd=0 (the ROB completes it), while setting no wakeup bit.
REQ-028 SHALL on flush=1 at an edge: empty all FIFOs, clear all lane valids, drop that cycle's enqueues, and hold rr_ptr.
REQ-029 SHALL wrap FIFO head and tail pointers modulo FIFO_DEPTH. The occupancy counter is $clog2(FIFO_DEPTH)+1 bits and never exceeds FIFO_DEPTH.
REQ-030 SHALL emit entries from the same source in enqueue order.

Reset
REQ-031 SHALL, while rst=0 (asynchronous), clear all FIFOs, set rr_ptr=0, drive cdb_lane_valid=0, cdb_valid=0 and all lane payloads 0, and drive src_ready all ones.
REQ-032 SHALL discard any in-flight buffered result on a mid-operation reset. On release, the first grant uses rr_ptr=0.

Verification
REQ-033 Single result: src_valid[3]=1, prd=7, rob=4, data=0xDEAD at cycle 0 -> cycle 2: lane0 valid {7,4,0xDEAD}, cdb_valid=bit 7 only, lane1 invalid.
REQ-034 Contention: sources 0, 1, 2 valid in the same cycle, rr_ptr=0 -> cycle 2: lanes carry sources 0 and 1; cycle 3: lane0 carries source 2; rr_ptr=3 afterward.
REQ-035 Backpressure: source 4 valid every cycle while other sources stream and starve it -> src_ready[4]=0 after 2 enqueues; no entry lost or reordered; all 2+ later results emitted in order.
REQ-036 prd=0: source 5 result with prd=0 -> lane valid=1 and cdb_valid all zero.
REQ-037 Flush: 3 sources buffered, flush=1 -> next cycle all lanes invalid, all src_ready=1, and no buffered result ever appears.
REQ-038 Async reset: rst=0 mid-stream between clock edges -> outputs clear immediately; after release, the first grant starts at source 0.
